// File: rtl/neuron_pkg.sv
// rtl/neuron_pkg.sv - constants and state encoding shared by the frame loader and neuron core.
package neuron_pkg;

    localparam int INPUTS   = 32;
    localparam int N_STAGES = 2;

    localparam logic [7:0] HDR_INPUT  = 8'h00;
    localparam logic [7:0] HDR_WEIGHT = 8'h80;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_CHECK   = 2'd2
    } loader_state_t;

endpackage

// File: rtl/neuron_frame_loader_shift.sv
// rtl/neuron_frame_loader_shift.sv - byte-wise staging shift register (frame_shift_reg).
// Byte k of a frame ends up in bits [8k+7:8k] once all INPUTS/8 bytes are shifted in.
module frame_shift_reg #(
    parameter int INPUTS  = 32,
    parameter int COUNT_W = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_clear,
    input  logic               i_shift,
    input  logic [7:0]         i_byte,
    output logic [INPUTS-1:0]  o_data,
    output logic [INPUTS-1:0]  o_next,
    output logic [COUNT_W-1:0] o_count
);

    logic [INPUTS-1:0]  r_data;
    logic [COUNT_W-1:0] r_count;
    logic [INPUTS-1:0]  w_next;

    generate
        if (INPUTS == 8) begin : g_single
            assign w_next = i_byte;
        end else begin : g_multi
            assign w_next = {i_byte, r_data[INPUTS-1:8]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_data  <= '0;
            r_count <= '0;
        end else if (i_shift) begin
            r_data  <= w_next;
            r_count <= r_count + 1'b1;
        end
    end

    assign o_data  = r_data;
    assign o_next  = w_next;
    assign o_count = r_count;

endmodule

// File: rtl/neuron_frame_loader.sv
// rtl/neuron_frame_loader.sv - header+payload byte stream to atomically committed x/w vectors.
// Optional trailing XOR checksum byte when LOADER_CHECKSUM_EN is defined.
module neuron_frame_loader #(
    parameter int INPUTS = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic [INPUTS-1:0] x,
    output logic              x_valid,
    output logic [INPUTS-1:0] w,
    output logic              w_loaded,
    output logic              frame_error,
    output logic              busy
);

    import neuron_pkg::*;

    localparam int N_BYTES = INPUTS / 8;
    localparam int COUNT_W = $clog2(N_BYTES + 1);

    loader_state_t      r_state;
    loader_state_t      w_next_state;
    logic               r_is_weight;
    logic               w_clear;
    logic               w_shift;
    logic               w_commit;
    logic               w_err;
    logic               w_last;
    logic [INPUTS-1:0]  w_stage;
    logic [INPUTS-1:0]  w_stage_next;
    logic [INPUTS-1:0]  w_commit_data;
    logic [COUNT_W-1:0] w_count;

    frame_shift_reg #(
        .INPUTS  (INPUTS),
        .COUNT_W (COUNT_W)
    ) u_stage (
        .clk     (clk),
        .reset   (reset),
        .i_clear (w_clear),
        .i_shift (w_shift),
        .i_byte  (byte_in),
        .o_data  (w_stage),
        .o_next  (w_stage_next),
        .o_count (w_count)
    );

    assign w_last = (w_count == COUNT_W'(N_BYTES - 1));

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] r_csum;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_csum <= '0;
        end else if (w_clear) begin
            r_csum <= byte_in;
        end else if (w_shift) begin
            r_csum <= r_csum ^ byte_in;
        end
    end

    // The staging register is already complete by the time the checksum byte arrives.
    assign w_commit_data = w_stage;
`else
    assign w_commit_data = w_stage_next;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_clear      = 1'b0;
        w_shift      = 1'b0;
        w_commit     = 1'b0;
        w_err        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (byte_valid) begin
                    if (byte_in == HDR_INPUT || byte_in == HDR_WEIGHT) begin
                        w_clear      = 1'b1;
                        w_next_state = ST_PAYLOAD;
                    end else begin
                        w_err = 1'b1;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (byte_valid) begin
                    w_shift = 1'b1;
                    if (w_last) begin
`ifdef LOADER_CHECKSUM_EN
                        w_next_state = ST_CHECK;
`else
                        w_commit     = 1'b1;
                        w_next_state = ST_IDLE;
`endif
                    end
                end
            end
            ST_CHECK: begin
`ifdef LOADER_CHECKSUM_EN
                if (byte_valid) begin
                    w_next_state = ST_IDLE;
                    if (byte_in == r_csum) begin
                        w_commit = 1'b1;
                    end else begin
                        w_err = 1'b1;
                    end
                end
`else
                w_next_state = ST_IDLE;
`endif
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_is_weight <= 1'b0;
            x           <= '0;
            w           <= '0;
            x_valid     <= 1'b0;
            w_loaded    <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            x_valid     <= 1'b0;
            frame_error <= w_err;
            if (w_clear) begin
                r_is_weight <= (byte_in == HDR_WEIGHT);
            end
            if (w_commit) begin
                if (r_is_weight) begin
                    w        <= w_commit_data;
                    w_loaded <= 1'b1;
                end else begin
                    x       <= w_commit_data;
                    x_valid <= 1'b1;
                end
            end
        end
    end

    assign busy = (r_state != ST_IDLE);

endmodule

// File: tb/tb_neuron_frame_loader.sv
// tb/tb_neuron_frame_loader.sv - directed and random frame stimulus against a frame-level reference model.
module tb_neuron_frame_loader;

    localparam int INPUTS  = 32;
    localparam int N_BYTES = INPUTS / 8;

    logic              clk = 1'b0;
    logic              reset;
    logic [7:0]        byte_in;
    logic              byte_valid;
    logic [INPUTS-1:0] x;
    logic              x_valid;
    logic [INPUTS-1:0] w;
    logic              w_loaded;
    logic              frame_error;
    logic              busy;

    int n_checks = 0;
    int n_errors = 0;

    logic [INPUTS-1:0] exp_x;
    logic [INPUTS-1:0] exp_w;
    logic              exp_loaded;

    neuron_frame_loader #(.INPUTS(INPUTS)) dut (
        .clk         (clk),
        .reset       (reset),
        .byte_in     (byte_in),
        .byte_valid  (byte_valid),
        .x           (x),
        .x_valid     (x_valid),
        .w           (w),
        .w_loaded    (w_loaded),
        .frame_error (frame_error),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        byte_in    = b;
        byte_valid = 1'b1;
        tick();
        byte_valid = 1'b0;
        byte_in    = 8'($urandom);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_x"}, x, 0);
        chk({tag, "_w"}, w, 0);
        chk({tag, "_xvalid"}, {31'd0, x_valid}, 0);
        chk({tag, "_wloaded"}, {31'd0, w_loaded}, 0);
        chk({tag, "_ferr"}, {31'd0, frame_error}, 0);
        chk({tag, "_busy"}, {31'd0, busy}, 0);
    endtask

    // gap < 0 selects a random 0..2 stall before each payload byte
    task automatic send_frame(input logic [7:0] hdr, input logic [31:0] data,
                              input int gap, input bit bad_csum);
        logic [7:0] cs;
        int         g;
        cs = hdr;
        send(hdr);
        chk("hdr_xvalid", {31'd0, x_valid}, 0);
        if (hdr != 8'h00 && hdr != 8'h80) begin
            chk("hdr_ferr", {31'd0, frame_error}, 1);
            chk("hdr_busy", {31'd0, busy}, 0);
            return;
        end
        chk("hdr_ferr", {31'd0, frame_error}, 0);
        chk("hdr_busy", {31'd0, busy}, 1);
        for (int k = 0; k < N_BYTES; k++) begin
            g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
            repeat (g) begin
                tick();
                chk("stall_busy", {31'd0, busy}, 1);
            end
            cs = cs ^ data[8*k +: 8];
            send(data[8*k +: 8]);
            if (k < N_BYTES - 1) begin
                chk("load_busy", {31'd0, busy}, 1);
                chk("load_x", x, exp_x);
                chk("load_w", w, exp_w);
            end
        end
`ifdef LOADER_CHECKSUM_EN
        chk("precs_busy", {31'd0, busy}, 1);
        chk("precs_xvalid", {31'd0, x_valid}, 0);
        chk("precs_x", x, exp_x);
        send(bad_csum ? (cs ^ 8'h01) : cs);
        if (bad_csum) begin
            chk("cs_ferr", {31'd0, frame_error}, 1);
            chk("cs_x", x, exp_x);
            chk("cs_w", w, exp_w);
            chk("cs_xvalid", {31'd0, x_valid}, 0);
            chk("cs_busy", {31'd0, busy}, 0);
            return;
        end
`endif
        if (hdr == 8'h00) begin
            exp_x = data;
        end else begin
            exp_w      = data;
            exp_loaded = 1'b1;
        end
        chk("cm_x", x, exp_x);
        chk("cm_w", w, exp_w);
        chk("cm_xvalid", {31'd0, x_valid}, {31'd0, hdr == 8'h00});
        chk("cm_wloaded", {31'd0, w_loaded}, {31'd0, exp_loaded});
        chk("cm_ferr", {31'd0, frame_error}, 0);
        chk("cm_busy", {31'd0, busy}, {31'd0, bad_csum & 1'b0});
    endtask

    task automatic idle_check();
        tick();
        chk("idle_xvalid", {31'd0, x_valid}, 0);
        chk("idle_ferr", {31'd0, frame_error}, 0);
        chk("idle_x", x, exp_x);
        chk("idle_w", w, exp_w);
    endtask

    initial begin
        logic [7:0] h;
        int         r;
        reset      = 1'b1;
        byte_valid = 1'b0;
        byte_in    = 8'h00;
        exp_x      = '0;
        exp_w      = '0;
        exp_loaded = 1'b0;
        tick();
        tick();
        chk_zero("rst");
        reset = 1'b0;
        tick();

        send_frame(8'h00, 32'h44332211, 0, 1'b0);
        idle_check();

        send_frame(8'h80, 32'hDEADBEEF, 2, 1'b0);
        idle_check();

        send_frame(8'h42, 32'h0, 0, 1'b0);
        idle_check();
        send_frame(8'h00, 32'h04030201, 0, 1'b0);
        idle_check();

        send(8'h00);
        send(8'hA1);
        send(8'hB2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_x      = '0;
        exp_w      = '0;
        exp_loaded = 1'b0;
        chk_zero("midrst");
        send_frame(8'h00, 32'h87654321, 0, 1'b0);
        idle_check();

        send_frame(8'h80, 32'h0F1E2D3C, 0, 1'b0);
        send_frame(8'h00, 32'hCAFEF00D, 0, 1'b0);
        idle_check();

`ifdef LOADER_CHECKSUM_EN
        send_frame(8'h00, 32'h04030201, 0, 1'b0);
        idle_check();
        send_frame(8'h00, 32'h11223344, 0, 1'b1);
        idle_check();
`endif

        for (int i = 0; i < 40; i++) begin
            r = int'($urandom_range(0, 9));
            if (r == 0) begin
                do h = 8'($urandom); while (h == 8'h00 || h == 8'h80);
            end else if (r < 6) begin
                h = 8'h00;
            end else begin
                h = 8'h80;
            end
            send_frame(h, $urandom, -1, ($urandom_range(0, 4) == 0));
            if ($urandom_range(0, 1) == 1) begin
                idle_check();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
